// File: rtl/controller_emulator.sv
// Gamepad-side responder for the serial latch/clock controller protocol.
// The host's latch and shift clock are synchronized into clk. The button
// word is parallel-loaded while latch is high. It is then presented one bit
// per accepted controller_clk rising edge on the active-low data line.
module controller_emulator #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic        MSB_FIRST      = 1'b0,
  parameter logic        TAIL_LEVEL     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic       clk,
  input  logic       rst_B,
  input  logic [7:0] buttons,
  input  logic       controller_clk,
  input  logic       controller_latch,
  output logic       controller_data_B,
  output logic       busy,
  output logic [2:0] bit_index,
  output logic       poll_done,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    TAIL
  } state_t;

  localparam logic [11:0] WD_LAST = 12'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] clk_sync, latch_sync;
  logic                   clk_prev, latch_prev;
  logic                   clk_s, latch_s, clk_rise, latch_fall;

  logic [7:0]  sr, sr_next, load_word;
  logic [11:0] wd, wd_next;
  logic [2:0]  index_next;
  logic        data_next, poll_done_next, timeout_next;

  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clk_rise   = clk_s & ~clk_prev;
  assign latch_fall = latch_prev & ~latch_s;

  // Bit-reverse the buttons when MSB first, so sr[0] is always the next bit out
  assign load_word = MSB_FIRST ? {<<{buttons}} : buttons;

  assign busy = (state != IDLE);

  // Synchronizer chains for the async host inputs, followed by an edge-detect register
  always_ff @(posedge clk) begin
    if (!rst_B) begin
      clk_sync   <= '0;
      latch_sync <= '0;
      clk_prev   <= 1'b0;
      latch_prev <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], controller_clk};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], controller_latch};
      clk_prev   <= clk_s;
      latch_prev <= latch_s;
    end
  end

  // Next-state and datapath: latch dominates everything; watchdog guards SHIFT and TAIL
  always_comb begin
    state_next     = state;
    sr_next        = sr;
    index_next     = bit_index;
    wd_next        = wd;
    poll_done_next = 1'b0;
    timeout_next   = 1'b0;
    if (latch_s) begin
      state_next = LOAD;
      sr_next    = load_word;
      index_next = 3'd0;
      wd_next    = 12'd0;
    end else begin
      case (state)
        IDLE: begin
          index_next = 3'd0;
        end
        LOAD: begin
          wd_next = 12'd0;
          if (latch_fall) begin
            state_next = SHIFT;
          end else begin
            sr_next = load_word;
          end
        end
        SHIFT, TAIL: begin
          if (state == SHIFT && clk_rise) begin
            wd_next = 12'd0;
            if (bit_index == 3'd7) begin
              state_next     = TAIL;
              poll_done_next = 1'b1;
            end else begin
              sr_next    = {1'b0, sr[7:1]};
              index_next = bit_index + 3'd1;
            end
          end else if (wd == WD_LAST) begin
            state_next   = IDLE;
            timeout_next = 1'b1;
            index_next   = 3'd0;
            wd_next      = 12'd0;
          end else begin
            wd_next = wd + 12'd1;
          end
        end
        default: begin
          state_next = IDLE;
          index_next = 3'd0;
          wd_next    = 12'd0;
        end
      endcase
    end

    case (state_next)
      LOAD, SHIFT: data_next = ~sr_next[0];
      TAIL:        data_next = TAIL_LEVEL;
      default:     data_next = 1'b1;
    endcase
  end

  // State register and registered outputs; reset drops any poll in progress
  always_ff @(posedge clk) begin
    if (!rst_B) begin
      state             <= IDLE;
      sr                <= 8'd0;
      wd                <= 12'd0;
      bit_index         <= 3'd0;
      controller_data_B <= 1'b1;
      poll_done         <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      state             <= state_next;
      sr                <= sr_next;
      wd                <= wd_next;
      bit_index         <= index_next;
      controller_data_B <= data_next;
      poll_done         <= poll_done_next;
      timeout           <= timeout_next;
    end
  end

endmodule

// File: tb/tb_controller_emulator.sv
// Bench for controller_emulator: drives the host side of the protocol with
// random button words and timing. Two instances run side by side with
// different configurations, and their serial streams are compared against
// expected words queued when each latch falls.
module tb_controller_emulator;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_B;
  logic [7:0] buttons;
  logic       ctrl_clk;
  logic       ctrl_latch;

  logic       data_b    [2];
  logic       busy      [2];
  logic [2:0] bit_idx   [2];
  logic       poll_done [2];
  logic       timeout   [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         exp_timeouts[2];
  int         got_timeouts[2];

  always #5 clk = ~clk;

  controller_emulator #(
    .SYNC_STAGES(2), .MSB_FIRST(1'b0), .TAIL_LEVEL(1'b0), .TIMEOUT_CYCLES(TMO)
  ) dut_lsb (
    .clk(clk), .rst_B(rst_B), .buttons(buttons),
    .controller_clk(ctrl_clk), .controller_latch(ctrl_latch),
    .controller_data_B(data_b[0]), .busy(busy[0]), .bit_index(bit_idx[0]),
    .poll_done(poll_done[0]), .timeout(timeout[0])
  );

  controller_emulator #(
    .SYNC_STAGES(3), .MSB_FIRST(1'b1), .TAIL_LEVEL(1'b1), .TIMEOUT_CYCLES(TMO)
  ) dut_msb (
    .clk(clk), .rst_B(rst_B), .buttons(buttons),
    .controller_clk(ctrl_clk), .controller_latch(ctrl_latch),
    .controller_data_B(data_b[1]), .busy(busy[1]), .bit_index(bit_idx[1]),
    .poll_done(poll_done[1]), .timeout(timeout[1])
  );

  // Reference model: the pin level seen at shift position i, for instance k
  function automatic logic [7:0] expected_word(input int k, input logic [7:0] b);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) begin
      w[i] = (k == 1) ? ~b[7-i] : ~b[i];
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s inst=%0d actual=%0h required=%0h", name, k, actual, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] b);
    exp_q0.push_back(expected_word(0, b));
    exp_q1.push_back(expected_word(1, b));
  endtask

  task automatic do_rises(input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_clk = 1'b1;
      cycles($urandom_range(5, 2));
      ctrl_clk = 1'b0;
      if ($urandom_range(1, 0) == 1) buttons = 8'($urandom);
      cycles($urandom_range(5, 2));
    end
  endtask

  // One host poll: latch pulse, n clock rises, optional idle long enough to time out
  task automatic applyStimulus(input logic [7:0] b, input int n_rises, input bit idle_after);
    buttons = b;
    cycles(2);
    ctrl_latch = 1'b1;
    cycles($urandom_range(6, 3));
    ctrl_latch = 1'b0;
    if (n_rises == 8) push_word(b);
    cycles(5);
    buttons = 8'($urandom);
    do_rises(n_rises);
    if (n_rises == 8 && $urandom_range(1, 0) == 1) begin
      ctrl_clk = 1'b1;
      cycles(2);
      ctrl_clk = 1'b0;
      cycles(2);
    end
    if (idle_after) begin
      cycles(30);
      exp_timeouts[0]++;
      exp_timeouts[1]++;
    end
  endtask

  // Monitor: rebuilds each shifted word from the outputs and scores it on poll_done
  initial begin : monitor
    logic [2:0] prev_idx  [2];
    logic       prev_data [2];
    logic [7:0] word      [2];
    logic [7:0] mask      [2];
    int         since     [2];
    logic [7:0] exp_w;
    for (int k = 0; k < 2; k++) begin
      prev_idx[k] = 3'd0; prev_data[k] = 1'b1; word[k] = 8'd0; mask[k] = 8'd0; since[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (!rst_B) begin
        for (int k = 0; k < 2; k++) begin
          prev_idx[k] = 3'd0; prev_data[k] = 1'b1; mask[k] = 8'd0; since[k] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (timeout[k]) begin
            got_timeouts[k]++;
            checkOutput("timeout_delay", k, since[k] + 1, TMO);
            checkOutput("timeout_busy", k, busy[k], 1'b0);
          end
          if (!busy[k]) checkOutput("idle_data", k, data_b[k], 1'b1);
          if (poll_done[k]) begin
            word[k][7] = prev_data[k];
            checkOutput("poll_bits_seen", k, mask[k], 8'h7F);
            checkOutput("poll_index", k, bit_idx[k], 3'd7);
            checkOutput("tail_level", k, data_b[k], (k == 1) ? 1'b1 : 1'b0);
            if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
              checkOutput("unexpected_poll_done", k, 1, 0);
            end else begin
              exp_w = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              checkOutput("poll_word", k, word[k], exp_w);
            end
          end else if (bit_idx[k] != prev_idx[k]) begin
            if (bit_idx[k] == 3'd0) begin
              mask[k] = 8'd0;
            end else begin
              checkOutput("index_step", k, bit_idx[k], prev_idx[k] + 3'd1);
              word[k][prev_idx[k]] = prev_data[k];
              mask[k][prev_idx[k]] = 1'b1;
            end
          end
          if (poll_done[k] || bit_idx[k] != prev_idx[k]) since[k] = 0;
          else since[k]++;
          prev_idx[k]  = bit_idx[k];
          prev_data[k] = data_b[k];
        end
      end
    end
  end

  // Directed scenarios first, then randomized polls, then end-of-run bookkeeping
  initial begin : stimulus
    logic [7:0] b;
    rst_B      = 1'b0;
    buttons    = 8'h00;
    ctrl_clk   = 1'b0;
    ctrl_latch = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_timeouts[k] = 0;
      got_timeouts[k] = 0;
    end

    // Reset held with the latch toggling
    for (int c = 0; c < 3; c++) begin
      ctrl_latch = ~ctrl_latch;
      cycles(1);
      for (int k = 0; k < 2; k++) begin
        checkOutput("reset_data", k, data_b[k], 1'b1);
        checkOutput("reset_busy", k, busy[k], 1'b0);
        checkOutput("reset_index", k, bit_idx[k], 3'd0);
        checkOutput("reset_pulses", k, {poll_done[k], timeout[k]}, 2'b00);
      end
    end
    ctrl_latch = 1'b0;
    rst_B = 1'b1;
    cycles(6);
    for (int k = 0; k < 2; k++) checkOutput("post_reset_busy", k, busy[k], 1'b0);

    // Spec example words
    applyStimulus(8'b10001001, 8, 1'b1);
    applyStimulus(8'b00100110, 8, 1'b1);

    // Live load while latch is high, then freeze after it falls
    buttons = 8'h00;
    cycles(2);
    ctrl_latch = 1'b1;
    cycles(5);
    for (int k = 0; k < 2; k++) begin
      checkOutput("load_busy", k, busy[k], 1'b1);
      checkOutput("load_data_before", k, data_b[k], 1'b1);
    end
    buttons = 8'h01;
    cycles(2);
    checkOutput("load_data_after", 0, data_b[0], 1'b0);
    checkOutput("load_data_after", 1, data_b[1], 1'b1);
    cycles(2);
    ctrl_latch = 1'b0;
    push_word(8'h01);
    cycles(5);
    buttons = 8'hFE;
    do_rises(8);
    cycles(30);
    exp_timeouts[0]++;
    exp_timeouts[1]++;

    // Abort after 3 shifts; latch rises together with a clock rise
    applyStimulus(8'($urandom), 3, 1'b0);
    buttons    = 8'hFF;
    ctrl_clk   = 1'b1;
    ctrl_latch = 1'b1;
    cycles(6);
    for (int k = 0; k < 2; k++) begin
      checkOutput("abort_index", k, bit_idx[k], 3'd0);
      checkOutput("abort_data", k, data_b[k], 1'b0);
      checkOutput("abort_busy", k, busy[k], 1'b1);
    end
    ctrl_clk = 1'b0;
    cycles(3);
    ctrl_latch = 1'b0;
    push_word(8'hFF);
    cycles(5);
    do_rises(8);
    cycles(30);
    exp_timeouts[0]++;
    exp_timeouts[1]++;

    // Watchdog after two accepted rises
    applyStimulus(8'($urandom), 2, 1'b1);

    // Reset mid-poll
    applyStimulus(8'($urandom), 4, 1'b0);
    rst_B = 1'b0;
    cycles(2);
    for (int k = 0; k < 2; k++) begin
      checkOutput("midreset_index", k, bit_idx[k], 3'd0);
      checkOutput("midreset_busy", k, busy[k], 1'b0);
    end
    rst_B = 1'b1;
    cycles(6);

    // Randomized polls
    for (int n = 0; n < 14; n++) begin
      b = 8'($urandom);
      applyStimulus(b, 8, 1'b1);
    end

    cycles(10);
    checkOutput("pending_polls", 0, exp_q0.size(), 0);
    checkOutput("pending_polls", 1, exp_q1.size(), 0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("timeout_count", k, got_timeouts[k], exp_timeouts[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
